// File: rtl/sif_txn_monitor_if.sv
// SIF X-side bus bundle (xa_*). The monitor modport observes every signal
// without driving anything, so the monitor can sit on a live bus.
interface sif_txn_monitor_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic [DATA_W-1:0] xa_data_rd;
    logic              xa_wr_s;
    logic              xa_rd_s;

    modport master (
        output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
        input  xa_data_rd
    );

    modport slave (
        input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
        output xa_data_rd
    );

    modport monitor (
        input xa_addr, xa_data_wr, xa_data_rd, xa_wr_s, xa_rd_s
    );
endinterface

// File: rtl/sif_txn_monitor.sv
// Passive SIF X-side transaction monitor: logs every accepted write/read into a
// show-ahead FIFO and keeps saturating write/read/drop counters plus a sticky protocol-error flag.
module sif_txn_monitor #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sif_txn_monitor_if.monitor         xa,
    input  logic                       mon_en,
    input  logic                       clear,
    input  logic                       log_pop,
    output logic                       log_valid,
    output logic                       log_is_wr,
    output logic [ADDR_W-1:0]          log_addr,
    output logic [DATA_W-1:0]          log_data,
    output logic [$clog2(DEPTH):0]     log_level,
    output logic [CNT_W-1:0]           wr_cnt,
    output logic [CNT_W-1:0]           rd_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Stage p0: issue decode on the level-sampled strobes
    logic              vld_p0;
    logic              is_wr_p0;
    logic              both_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    always_comb begin
        both_p0  = xa.xa_wr_s & xa.xa_rd_s;
        vld_p0   = mon_en & (xa.xa_wr_s ^ xa.xa_rd_s);
        is_wr_p0 = xa.xa_wr_s;
        addr_p0  = xa.xa_addr;
        wdata_p0 = xa.xa_data_wr;
    end

    // Stage p1: completion, RD_LAT edges after issue (writes delayed too, keeping log order)
    logic              vld_p1;
    logic              is_wr_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;

    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign vld_p1   = vld_p0;
            assign is_wr_p1 = is_wr_p0;
            assign addr_p1  = addr_p0;
            assign wdata_p1 = wdata_p0;
        end else begin : g_lat
            logic              vld_dly   [RD_LAT];
            logic              is_wr_dly [RD_LAT];
            logic [ADDR_W-1:0] addr_dly  [RD_LAT];
            logic [DATA_W-1:0] wdata_dly [RD_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT; i++) vld_dly[i] <= 1'b0;
                end else if (clear) begin
                    for (int i = 0; i < RD_LAT; i++) vld_dly[i] <= 1'b0;
                end else begin
                    vld_dly[0] <= vld_p0;
                    for (int i = 1; i < RD_LAT; i++) vld_dly[i] <= vld_dly[i-1];
                end
            end

            // Payload only qualifies through vld_dly, so it needs no reset
            always_ff @(posedge clk) begin
                is_wr_dly[0] <= is_wr_p0;
                addr_dly[0]  <= addr_p0;
                wdata_dly[0] <= wdata_p0;
                for (int i = 1; i < RD_LAT; i++) begin
                    is_wr_dly[i] <= is_wr_dly[i-1];
                    addr_dly[i]  <= addr_dly[i-1];
                    wdata_dly[i] <= wdata_dly[i-1];
                end
            end

            assign vld_p1   = vld_dly[RD_LAT-1];
            assign is_wr_p1 = is_wr_dly[RD_LAT-1];
            assign addr_p1  = addr_dly[RD_LAT-1];
            assign wdata_p1 = wdata_dly[RD_LAT-1];
        end
    endgenerate

    logic [DATA_W-1:0] data_p1;
    assign data_p1 = is_wr_p1 ? wdata_p1 : xa.xa_data_rd;

    logic              mem_is_wr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              full;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;

    // A pop frees the slot at the same edge, so a full FIFO still accepts a push then
    always_comb begin
        full    = (count == FULL_LVL);
        pop_ok  = log_pop & (count != '0);
        push_ok = vld_p1 & (~full | pop_ok);
        drop    = vld_p1 & full & ~pop_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + LVL_W'(push_ok) - LVL_W'(pop_ok);
            if (vld_p1 &  is_wr_p1) wr_cnt   <= sat_inc(wr_cnt);
            if (vld_p1 & ~is_wr_p1) rd_cnt   <= sat_inc(rd_cnt);
            if (drop)               drop_cnt <= sat_inc(drop_cnt);
            if (mon_en & both_p0)   proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_is_wr[wr_ptr] <= is_wr_p1;
            mem_addr[wr_ptr]  <= addr_p1;
            mem_data[wr_ptr]  <= data_p1;
        end
    end

    // Head view: live FIFO head when non-empty, otherwise the last value shown
    logic              last_is_wr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    always_comb begin
        log_valid = (count != '0);
        log_is_wr = last_is_wr;
        log_addr  = last_addr;
        log_data  = last_data;
        if (log_valid) begin
            log_is_wr = mem_is_wr[rd_ptr];
            log_addr  = mem_addr[rd_ptr];
            log_data  = mem_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_is_wr <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
        end else begin
            last_is_wr <= log_is_wr;
            last_addr  <= log_addr;
            last_data  <= log_data;
        end
    end

    assign log_level = count;
endmodule

// File: tb/tb_sif_txn_monitor.sv
// Bench for sif_txn_monitor: four instances (RD_LAT 0..3, mixed DEPTH) share one bus,
// directed scenarios check constants, a random run checks against a queue-based model.
module tb_sif_txn_monitor;
    localparam int N = 4;

    function automatic int lat_of(input int k);
        return k;
    endfunction

    function automatic int dep_of(input int k);
        return (k == 0) ? 2 : ((k == 2) ? 8 : 4);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mon_en;
    logic clear;
    logic log_pop;

    sif_txn_monitor_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    logic        vld  [N];
    logic        iswr [N];
    logic [15:0] addr [N];
    logic [15:0] data [N];
    logic [3:0]  lvl  [N];
    logic [15:0] wc   [N];
    logic [15:0] rc   [N];
    logic [15:0] dc   [N];
    logic        perr [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = g;
        localparam int DEP = (g == 0) ? 2 : ((g == 2) ? 8 : 4);
        logic [$clog2(DEP):0] lvl_g;

        sif_txn_monitor #(
            .ADDR_W(16), .DATA_W(16), .DEPTH(DEP), .RD_LAT(LAT), .CNT_W(16)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .xa        (bus),
            .mon_en    (mon_en),
            .clear     (clear),
            .log_pop   (log_pop),
            .log_valid (vld[g]),
            .log_is_wr (iswr[g]),
            .log_addr  (addr[g]),
            .log_data  (data[g]),
            .log_level (lvl_g),
            .wr_cnt    (wc[g]),
            .rd_cnt    (rc[g]),
            .drop_cnt  (dc[g]),
            .proto_err (perr[g])
        );
        assign lvl[g] = 4'(lvl_g);
    end

    // Reference model: list of outstanding issues with due edge, and a bounded entry list
    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;

    typedef struct packed {
        int          due;
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } pend_t;

    ent_t        m_fifo [N][$];
    pend_t       m_pend [N][$];
    logic [15:0] m_wc   [N];
    logic [15:0] m_rc   [N];
    logic [15:0] m_dc   [N];
    logic        m_err  [N];
    ent_t        m_last [N];
    int          cyc;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_fifo[k].delete();
            m_pend[k].delete();
            m_wc[k]   = '0;
            m_rc[k]   = '0;
            m_dc[k]   = '0;
            m_err[k]  = 1'b0;
            m_last[k] = '0;
        end
    endfunction

    // Applies the rules for one rising edge using the inputs currently driven
    function automatic void model_edge();
        pend_t p;
        ent_t  e;
        bit    pop_ok;
        bit    full;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (clear) begin
                m_fifo[k].delete();
                m_pend[k].delete();
                m_wc[k]  = '0;
                m_rc[k]  = '0;
                m_dc[k]  = '0;
                m_err[k] = 1'b0;
            end else begin
                if (mon_en) begin
                    if (bus.xa_wr_s && bus.xa_rd_s) m_err[k] = 1'b1;
                    else if (bus.xa_wr_s || bus.xa_rd_s)
                        m_pend[k].push_back('{cyc + lat_of(k), bus.xa_wr_s, bus.xa_addr, bus.xa_data_wr});
                end
                pop_ok = log_pop && (m_fifo[k].size() > 0);
                full   = (m_fifo[k].size() == dep_of(k));
                if (pop_ok) void'(m_fifo[k].pop_front());
                if (m_pend[k].size() > 0 && m_pend[k][0].due == cyc) begin
                    p       = m_pend[k].pop_front();
                    e.is_wr = p.is_wr;
                    e.addr  = p.addr;
                    e.data  = p.is_wr ? p.wdata : bus.xa_data_rd;
                    if (p.is_wr) m_wc[k] = sat16(m_wc[k]);
                    else         m_rc[k] = sat16(m_rc[k]);
                    if (!full || pop_ok) m_fifo[k].push_back(e);
                    else                 m_dc[k] = sat16(m_dc[k]);
                end
            end
            if (m_fifo[k].size() > 0) m_last[k] = m_fifo[k][0];
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.xa_wr_s    = 1'b0;
        bus.xa_rd_s    = 1'b0;
        bus.xa_addr    = 16'h0000;
        bus.xa_data_wr = 16'h0000;
        bus.xa_data_rd = 16'hFFFF;
        mon_en         = 1'b1;
        clear          = 1'b0;
        log_pop        = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({vld[k], iswr[k], addr[k], data[k], lvl[k], wc[k], rc[k], dc[k], perr[k]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d got vld=%b lvl=%0d addr=%h data=%h wc=%0d rc=%0d dc=%0d err=%b, want all zero",
                         k, vld[k], lvl[k], addr[k], data[k], wc[k], rc[k], dc[k], perr[k]);
            end
        end
    endtask

    task automatic test_write();
        do_clear();
        bus.xa_wr_s = 1'b1; bus.xa_addr = 16'h0010; bus.xa_data_wr = 16'hBEEF;
        tick();
        set_idle();
        checks++;
        if ({vld[0], iswr[0], addr[0], data[0]} !== {1'b1, 1'b1, 16'h0010, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_lat0 got vld=%b wr=%b addr=%h data=%h, want 1 1 0010 beef", vld[0], iswr[0], addr[0], data[0]);
        end
        checks++;
        if (vld[1] !== 1'b0) begin
            errors++;
            $display("FAIL write_lat1_early got vld=%b, want 0", vld[1]);
        end
        tick();
        checks++;
        if ({vld[1], iswr[1], addr[1], data[1], wc[1], rc[1]} !== {1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL write_lat1 got vld=%b wr=%b addr=%h data=%h wc=%0d rc=%0d, want 1 1 0010 beef 1 0",
                     vld[1], iswr[1], addr[1], data[1], wc[1], rc[1]);
        end
    endtask

    task automatic test_read();
        do_clear();
        bus.xa_rd_s = 1'b1; bus.xa_addr = 16'h0020;
        tick();
        set_idle();
        tick();
        bus.xa_data_rd = 16'h1234;
        tick();
        bus.xa_data_rd = 16'hFFFF;
        checks++;
        if ({vld[2], iswr[2], addr[2], data[2], rc[2], wc[2]} !== {1'b1, 1'b0, 16'h0020, 16'h1234, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL read_lat2 got vld=%b wr=%b addr=%h data=%h rc=%0d wc=%0d, want 1 0 0020 1234 1 0",
                     vld[2], iswr[2], addr[2], data[2], rc[2], wc[2]);
        end
        checks++;
        if ({vld[1], data[1]} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL read_lat1_sample got vld=%b data=%h, want 1 ffff", vld[1], data[1]);
        end
    endtask

    task automatic test_proto_err();
        do_clear();
        bus.xa_wr_s = 1'b1; bus.xa_rd_s = 1'b1; bus.xa_addr = 16'h0099;
        tick();
        bus.xa_rd_s = 1'b0; bus.xa_addr = 16'h0001; bus.xa_data_wr = 16'h0002;
        tick();
        set_idle();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({perr[1], lvl[1], iswr[1], addr[1], data[1], wc[1], rc[1]} !== {1'b1, 4'd1, 1'b1, 16'h0001, 16'h0002, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL proto_err got err=%b lvl=%0d wr=%b addr=%h data=%h wc=%0d rc=%0d, want 1 1 1 0001 0002 1 0",
                     perr[1], lvl[1], iswr[1], addr[1], data[1], wc[1], rc[1]);
        end
        do_clear();
        // With monitoring off, neither error detection nor issue happens
        mon_en = 1'b0; bus.xa_wr_s = 1'b1; bus.xa_rd_s = 1'b1;
        tick();
        bus.xa_rd_s = 1'b0;
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) tick();
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({perr[k], vld[k], wc[k], rc[k]} !== {1'b0, 1'b0, 16'd0, 16'd0}) begin
                errors++;
                $display("FAIL clear_and_disable dut%0d got err=%b vld=%b wc=%0d rc=%0d, want 0 0 0 0", k, perr[k], vld[k], wc[k], rc[k]);
            end
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 6; i++) begin
            bus.xa_wr_s = 1'b1; bus.xa_addr = 16'(i); bus.xa_data_wr = 16'hA000 + 16'(i);
            tick();
        end
        set_idle();
        tick();
        checks++;
        if ({lvl[1], dc[1], wc[1]} !== {4'd4, 16'd2, 16'd6}) begin
            errors++;
            $display("FAIL overflow_counts got lvl=%0d dc=%0d wc=%0d, want 4 2 6", lvl[1], dc[1], wc[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({vld[1], addr[1], data[1]} !== {1'b1, 16'(i), 16'hA000 + 16'(i)}) begin
                errors++;
                $display("FAIL overflow_pop%0d got vld=%b addr=%h data=%h, want 1 %h %h", i, vld[1], addr[1], data[1], 16'(i), 16'hA000 + 16'(i));
            end
            log_pop = 1'b1;
            tick();
            log_pop = 1'b0;
        end
        checks++;
        if ({vld[1], lvl[1]} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL overflow_drained got vld=%b lvl=%0d, want 0 0", vld[1], lvl[1]);
        end
    endtask

    task automatic test_full_push_pop();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            bus.xa_wr_s = 1'b1; bus.xa_addr = 16'h0100 + 16'(i); bus.xa_data_wr = 16'hB000 + 16'(i);
            tick();
        end
        set_idle();
        checks++;
        if ({lvl[1], dc[1]} !== {4'd4, 16'd0}) begin
            errors++;
            $display("FAIL full_before got lvl=%0d dc=%0d, want 4 0", lvl[1], dc[1]);
        end
        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
        checks++;
        if ({vld[1], lvl[1], dc[1], addr[1]} !== {1'b1, 4'd4, 16'd0, 16'h0101}) begin
            errors++;
            $display("FAIL full_push_pop got vld=%b lvl=%0d dc=%0d addr=%h, want 1 4 0 0101", vld[1], lvl[1], dc[1], addr[1]);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        bus.xa_rd_s = 1'b1; bus.xa_addr = 16'h0055;
        tick();
        set_idle();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({vld[k], iswr[k], addr[k], data[k], lvl[k], wc[k], rc[k], dc[k], perr[k]} !== '0) begin
                errors++;
                $display("FAIL async_reset dut%0d got vld=%b lvl=%0d addr=%h data=%h rc=%0d, want all zero",
                         k, vld[k], lvl[k], addr[k], data[k], rc[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({vld[3], rc[3]} !== {1'b0, 16'd0}) begin
                errors++;
                $display("FAIL after_reset cycle%0d got vld=%b rc=%0d, want 0 0", i, vld[3], rc[3]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        int pop_pct;
        do_clear();
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            bus.xa_wr_s    = (r < 35) || (r >= 70 && r < 73);
            bus.xa_rd_s    = (r >= 35 && r < 73);
            bus.xa_addr    = 16'($urandom);
            bus.xa_data_wr = 16'($urandom);
            bus.xa_data_rd = 16'($urandom);
            mon_en         = ($urandom_range(0, 99) < 90);
            clear          = ($urandom_range(0, 99) < 2);
            pop_pct        = ((i / 100) % 2 == 1) ? 70 : 15;
            log_pop        = (int'($urandom_range(0, 99)) < pop_pct);
            tick();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({vld[k], iswr[k], addr[k], data[k]} !== {m_fifo[k].size() > 0, m_last[k]}) begin
                    errors++;
                    $display("FAIL rand_head dut%0d step%0d got vld=%b wr=%b addr=%h data=%h, want vld=%b wr=%b addr=%h data=%h",
                             k, i, vld[k], iswr[k], addr[k], data[k], m_fifo[k].size() > 0,
                             m_last[k].is_wr, m_last[k].addr, m_last[k].data);
                end
                checks++;
                if ({lvl[k], wc[k], rc[k], dc[k], perr[k]} !== {4'(m_fifo[k].size()), m_wc[k], m_rc[k], m_dc[k], m_err[k]}) begin
                    errors++;
                    $display("FAIL rand_stats dut%0d step%0d got lvl=%0d wc=%0d rc=%0d dc=%0d err=%b, want %0d %0d %0d %0d %b",
                             k, i, lvl[k], wc[k], rc[k], dc[k], perr[k], m_fifo[k].size(), m_wc[k], m_rc[k], m_dc[k], m_err[k]);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_write();
        test_read();
        test_proto_err();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sif_txn_monitor.md
Name: sif_txn_monitor

Overview:
- Parametrised, synthesizable transaction monitor for the SIF X-side bus (xa_* signals). It passively samples the bus every clock.
- Each accepted write or read becomes a log entry holding type, address and data. Entries go into a show-ahead FIFO that the bench or a debug master drains.
- Also keeps saturating write/read/drop counters and a sticky protocol-error flag. Replaces print-only monitoring with a checkable record.

Parameters:
- ADDR_W, 16, address width of xa_addr
- DATA_W, 16, width of xa_data_wr / xa_data_rd
- DEPTH, 8, log FIFO entries; power of two, minimum 2
- RD_LAT, 1, cycles from read strobe to valid xa_data_rd; range 0..3
- CNT_W, 16, width of all statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- xa_addr  in  ADDR_W  observed address
- xa_data_wr  in  DATA_W  observed write data
- xa_data_rd  in  DATA_W  observed read data
- xa_wr_s  in  1  observed write strobe
- xa_rd_s  in  1  observed read strobe
- mon_en  in  1  capture enable
- clear  in  1  synchronous clear of log, counters and error flag
- log_pop  in  1  consume head entry
- log_valid  out  1  FIFO not empty
- log_is_wr  out  1  head entry type: 1 = write, 0 = read
- log_addr  out  ADDR_W  head entry address
- log_data  out  DATA_W  head entry data
- log_level  out  $clog2(DEPTH)+1  entries held
- wr_cnt  out  CNT_W  accepted writes
- rd_cnt  out  CNT_W  accepted reads
- drop_cnt  out  CNT_W  entries lost to a full FIFO
- proto_err  out  1  sticky flag: both strobes seen high together

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, async):
  - FIFO empty, log_valid=0, log_level=0.
  - log_is_wr/addr/data=0.
  - All counters=0, proto_err=0.
  - Issue pipeline flushed.
- Issue: at a rising edge with mon_en=1 and rst_n=1:
  - xa_wr_s=1, xa_rd_s=0: write issue; captures xa_addr and xa_data_wr.
  - xa_rd_s=1, xa_wr_s=0: read issue; captures xa_addr.
  - Both high: no issue; proto_err set (sticky).
  - Strobes are level-sampled: a strobe held N cycles gives N issues.
  - mon_en=0: nothing issued, no error detection. Entries already in flight still complete.
- Completion pipeline, RD_LAT stages, carrying {valid, is_wr, addr, wdata}:
  - Every issue completes exactly RD_LAT edges after its issue edge. Writes are delayed too, so log order equals issue order.
  - A read completion samples xa_data_rd at its completion edge. With RD_LAT=0 that is the issue edge.
  - A write completion uses the captured wdata.
  - At most one completion per cycle.
- Completion bookkeeping:
  - Increments wr_cnt or rd_cnt, saturating at all-ones.
  - Pushes the entry if the FIFO is not full. Otherwise the entry is discarded and drop_cnt increments (saturating). Type counters count regardless of drop.
- FIFO (show-ahead):
  - Head entry is driven on log_* whenever log_valid=1.
  - A pushed entry is visible the cycle after its push edge.
  - log_pop with log_valid=1 removes the head at the edge. log_pop with log_valid=0 is ignored.
  - Push and pop at the same edge when full: both take effect, no drop, level unchanged.
  - Push and pop at the same edge when empty: the push only.
  - Read/write pointers wrap modulo DEPTH.
  - When empty, log_is_wr/addr/data hold their last values.
- clear=1 at an edge:
  - Empties the FIFO, zeros counters, clears proto_err, flushes the pipeline.
  - Same-edge issues and completions are discarded. clear has priority over everything except rst_n.
- Reset mid-operation: in-flight reads are lost; no entry is produced after reset for any pre-reset issue.

Test Plan:
- RD_LAT=1: write addr 0x0010 data 0xBEEF, one cycle -> one edge later log_valid=1, is_wr=1, addr=0x0010, data=0xBEEF; wr_cnt=1.
- RD_LAT=2: read addr 0x0020, xa_data_rd=0x1234 exactly 2 edges later (0xFFFF on other cycles) -> entry is_wr=0, addr=0x0020, data=0x1234; rd_cnt=1.
- Both strobes high one cycle, then write 0x0001/0x0002 -> proto_err=1 and stays 1; only the write logged; wr_cnt=1, rd_cnt=0; clear -> proto_err=0.
- DEPTH=4, six back-to-back writes (addr 0..5), no pops -> log_level=4, drop_cnt=2, wr_cnt=6; pops return addr 0,1,2,3, then log_valid=0.
- FIFO full and a completion arrives with log_pop=1 at the same edge -> drop_cnt unchanged, log_level stays 4, new head = the old second entry.
- RD_LAT=3 read issued, rst_n pulsed low (async, mid-cycle) before completion -> all outputs 0 immediately, no entry ever appears, rd_cnt=0.
